// File: rtl/bus_write_drain_pkg.sv
// Shared layout of the write-drain FIFO entry: default widths, field positions and
// the drain FSM encoding, used by the FIFO, its writer and the drain block.
package bus_write_drain_pkg;

  localparam int DWIDTH_DEF = 40;
  localparam int AWIDTH_DEF = 24;

  // Entry layout: address in the upper AWIDTH bits, data in the remaining low bits.
  function automatic int addr_msb(input int dw);
    return dw - 1;
  endfunction

  function automatic int addr_lsb(input int dw, input int aw);
    return dw - aw;
  endfunction

  function automatic int data_msb(input int dw, input int aw);
    return dw - aw - 1;
  endfunction

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

endpackage

// File: rtl/bus_write_drain.sv
// Pops write entries from an upstream FIFO and issues each as one bus write,
// abandoning (and flagging) any write not acknowledged within TIMEOUT cycles.
module bus_write_drain
  import bus_write_drain_pkg::*;
#(
  parameter int DWIDTH  = DWIDTH_DEF,
  parameter int AWIDTH  = AWIDTH_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     fifo_empty,
  input  logic [DWIDTH-1:0]        fifo_rd_data,
  output logic                     fifo_rd,
  output logic [AWIDTH-1:0]        bus_addr,
  output logic [DWIDTH-AWIDTH-1:0] bus_data,
  output logic                     bus_req,
  input  logic                     bus_ack,
  output logic                     busy,
  output logic                     timeout_err,
  input  logic                     err_clr,
  output logic [15:0]              xfer_count
);

  localparam int ADDR_MSB = addr_msb(DWIDTH);
  localparam int ADDR_LSB = addr_lsb(DWIDTH, AWIDTH);
  localparam int DATA_MSB = data_msb(DWIDTH, AWIDTH);
  localparam int TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_e                   state_q, state_d;
  logic                     req_q, req_d;
  logic [AWIDTH-1:0]        addr_q, addr_d;
  logic [DWIDTH-AWIDTH-1:0] data_q, data_d;
  logic                     err_q, err_d;
  logic [15:0]              xfer_count_q, xfer_count_d;
  logic [TW-1:0]            tmo_q, tmo_d;
  logic                     pop;

  // Pop is suppressed while reset is held so the FIFO never advances under reset.
  assign pop = reset_n & (state_q == ST_IDLE) & enable & ~fifo_empty;

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    addr_d       = addr_q;
    data_d       = data_q;
    err_d        = err_q & ~err_clr;
    xfer_count_d = xfer_count_q;
    tmo_d        = tmo_q;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          addr_d  = fifo_rd_data[ADDR_MSB:ADDR_LSB];
          data_d  = fifo_rd_data[DATA_MSB:0];
          tmo_d   = '0;
        end
      end
      ST_REQ: begin
        // An ack in the final allowed cycle still counts as a completed write.
        if (bus_ack) begin
          state_d      = ST_IDLE;
          req_d        = 1'b0;
          xfer_count_d = xfer_count_q + 16'd1;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      req_q        <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      err_q        <= 1'b0;
      xfer_count_q <= '0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      err_q        <= err_d;
      xfer_count_q <= xfer_count_d;
      tmo_q        <= tmo_d;
    end
  end

  assign fifo_rd     = pop;
  assign bus_addr    = addr_q;
  assign bus_data    = data_q;
  assign bus_req     = req_q;
  assign busy        = (state_q != ST_IDLE);
  assign timeout_err = err_q;
  assign xfer_count  = xfer_count_q;

endmodule

// File: tb/tb_bus_write_drain.sv
// Directed bench for bus_write_drain: a vector table of single transfers plus
// hand sequences for back-to-back, enable drop with counter wrap, reset mid-transfer.
module tb_bus_write_drain;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        bus_ack = 1'b0;
  logic        err_clr = 1'b0;
  logic        fifo_empty, fifo_rd, bus_req, busy, timeout_err;
  logic [39:0] fifo_rd_data;
  logic [23:0] bus_addr;
  logic [15:0] bus_data, xfer_count;

  logic [39:0] fmem [0:15];
  logic [3:0]  wp = 4'd0;
  logic [3:0]  rp = 4'd0;

  int checks = 0;
  int errors = 0;
  int pops = 0;
  int rd_empty = 0;
  int cyc = 0;
  int last_pop = 0;
  int prev_pop = 0;

  bus_write_drain #(.DWIDTH(40), .AWIDTH(24), .TIMEOUT(8)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_rd_data(fifo_rd_data), .fifo_rd(fifo_rd), .bus_addr(bus_addr),
    .bus_data(bus_data), .bus_req(bus_req), .bus_ack(bus_ack), .busy(busy),
    .timeout_err(timeout_err), .err_clr(err_clr), .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  assign fifo_empty   = (wp == rp);
  assign fifo_rd_data = fmem[rp];

  // Upstream FIFO model: head advances at every edge where fifo_rd is high.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd) begin
      rp       <= rp + 4'd1;
      pops     <= pops + 1;
      prev_pop <= last_pop;
      last_pop <= cyc;
      if (fifo_empty) rd_empty <= rd_empty + 1;
    end
  end

  task automatic push(input logic [39:0] e);
    fmem[wp] = e;
    wp = wp + 4'd1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [39:0] entry;
    int          ack_at;
    int          clr_at;
    logic [23:0] exp_addr;
    logic [15:0] exp_data;
    int          exp_cycles;
    int          exp_inc;
    logic        exp_err;
  } vec_t;

  vec_t        vecs [7];
  int          n, bound, p0;
  logic        seen, stable;
  logic [23:0] a1;
  logic [15:0] d1;
  logic [15:0] exp_cnt;

  initial begin
    vecs[0] = '{40'h12_3456_ABCD, 3, 0, 24'h123456, 16'hABCD, 3, 1, 1'b0};
    vecs[1] = '{40'hFF_FFFF_FFFF, 1, 0, 24'hFFFFFF, 16'hFFFF, 1, 1, 1'b0};
    vecs[2] = '{40'h00_0001_8000, 0, 0, 24'h000001, 16'h8000, 8, 0, 1'b1};
    vecs[3] = '{40'hA5_5A5A_0F0F, 8, 0, 24'hA55A5A, 16'h0F0F, 8, 1, 1'b0};
    vecs[4] = '{40'h80_0000_0001, 7, 0, 24'h800000, 16'h0001, 7, 1, 1'b0};
    vecs[5] = '{40'h3C_C3C3_5AA5, 0, 8, 24'h3CC3C3, 16'h5AA5, 8, 0, 1'b1};
    vecs[6] = '{40'h00_0000_0000, 2, 0, 24'h000000, 16'h0000, 2, 1, 1'b0};
    exp_cnt = 16'd0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req", bus_req, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_data", bus_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", timeout_err, 0);
    chk("rst_cnt", xfer_count, 0);
    chk("rst_rd", fifo_rd, 0);
    reset_n = 1'b1;
    enable  = 1'b1;
    @(negedge clk);

    // Vector table: one transfer each, error flag cleared beforehand
    for (int v = 0; v < 7; v++) begin
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk($sformatf("v%0d_errclr", v), timeout_err, 0);
      p0 = pops;
      push(vecs[v].entry);
      n = 0; seen = 1'b0; stable = 1'b1; bound = 0; a1 = '0; d1 = '0;
      while (bound < 40) begin
        @(negedge clk);
        bound++;
        if (bus_req) begin
          n++;
          if (!seen) begin a1 = bus_addr; d1 = bus_data; end
          seen = 1'b1;
          if (bus_addr !== vecs[v].exp_addr || bus_data !== vecs[v].exp_data) stable = 1'b0;
          bus_ack = (n == vecs[v].ack_at);
          err_clr = (n == vecs[v].clr_at);
        end else begin
          bus_ack = 1'b0;
          err_clr = 1'b0;
          if (seen) break;
        end
      end
      exp_cnt = exp_cnt + 16'(vecs[v].exp_inc);
      chk($sformatf("v%0d_done", v), {seen, bus_req}, 2'b10);
      chk($sformatf("v%0d_addr", v), a1, vecs[v].exp_addr);
      chk($sformatf("v%0d_data", v), d1, vecs[v].exp_data);
      chk($sformatf("v%0d_stable", v), stable, 1);
      chk($sformatf("v%0d_reqcyc", v), n, vecs[v].exp_cycles);
      chk($sformatf("v%0d_cnt", v), xfer_count, exp_cnt);
      chk($sformatf("v%0d_err", v), timeout_err, vecs[v].exp_err);
      chk($sformatf("v%0d_pops", v), pops - p0, 1);
      chk($sformatf("v%0d_busy", v), busy, 0);
    end

    // Back-to-back with a responder acking one cycle after it sees bus_req
    p0 = pops; n = 0; bound = 0;
    push(40'h01_0203_0405);
    push(40'h06_0708_090A);
    while (bound < 30) begin
      @(negedge clk);
      bound++;
      if (bus_req) begin n++; bus_ack = (n == 2); end
      else begin n = 0; bus_ack = 1'b0; end
      if (pops == p0 + 2 && !busy) break;
    end
    exp_cnt = exp_cnt + 16'd2;
    chk("b2b_done", bound < 30, 1);
    chk("b2b_pops", pops - p0, 2);
    chk("b2b_gap", last_pop - prev_pop, 3);
    chk("b2b_cnt", xfer_count, exp_cnt);
    chk("b2b_empty", fifo_empty, 1);

    // Preload the counter rather than clocking 65535 transfers
    force dut.xfer_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.xfer_count_q;
    @(negedge clk);
    exp_cnt = 16'hFFFF;
    chk("pre_cnt", xfer_count, exp_cnt);

    // Enable drop mid-REQ, transfer completes and counter wraps
    p0 = pops; n = 0; seen = 1'b0; bound = 0;
    push(40'h11_2233_4455);
    push(40'h66_7788_99AA);
    while (bound < 30) begin
      @(negedge clk);
      bound++;
      if (bus_req) begin
        n++; seen = 1'b1;
        if (n == 1) enable = 1'b0;
        bus_ack = (n == 2);
      end else begin
        bus_ack = 1'b0;
        if (seen) break;
      end
    end
    repeat (5) @(negedge clk);
    chk("en_wrap_cnt", xfer_count, 16'h0000);
    chk("en_pops", pops - p0, 1);
    chk("en_notempty", fifo_empty, 0);
    chk("en_busy", busy, 0);
    chk("en_rd", fifo_rd, 0);

    // Reset two cycles into REQ
    enable = 1'b1;
    p0 = pops; n = 0; bound = 0;
    while (bound < 20) begin
      @(negedge clk);
      bound++;
      if (bus_req) n++;
      if (n == 2) break;
    end
    chk("mr_reached", n, 2);
    reset_n = 1'b0;
    #1;
    chk("mr_req", bus_req, 0);
    chk("mr_addr", bus_addr, 0);
    chk("mr_data", bus_data, 0);
    chk("mr_cnt", xfer_count, 0);
    chk("mr_err", timeout_err, 0);
    chk("mr_busy", busy, 0);
    push(40'hDE_ADBE_EF01);
    #1;
    chk("mr_rd", fifo_rd, 0);
    repeat (2) @(negedge clk);
    chk("mr_nopop", pops - p0, 1);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rel_pop", pops - p0, 2);
    chk("rel_req", bus_req, 1);
    chk("rel_addr", bus_addr, 24'hDEADBE);
    chk("rel_data", bus_data, 16'hEF01);
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("rel_cnt", xfer_count, 1);

    // Ack in IDLE is ignored
    p0 = pops;
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_cnt", xfer_count, 1);
    chk("idle_ack_busy", busy, 0);
    chk("idle_ack_pops", pops - p0, 0);

    chk("rd_when_empty", rd_empty, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
